// File: rtl/score_pkg.sv
// Shared definitions for the score display: 7-segment glyphs and FSM states.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, done pulses one cycle
// after the last shift.
module bin2bcd_seq #(
    parameter int SCORE_W = 14,
    parameter int BCD_W   = 20
) (
    input  logic               clk2,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] score,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    localparam int CNT_W    = $clog2(SCORE_W + 1);
    localparam int NIBBLES  = BCD_W / 4;

    logic [SCORE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_active;
    logic               r_done;
    logic [BCD_W-1:0]   w_adj;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? (r_bcd[4*gi +: 4] + 4'd3)
                                                                : r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk2) begin
        if (reset) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bin    <= score;
                r_bcd    <= '0;
                r_cnt    <= '0;
                r_active <= 1'b1;
            end else if (r_active) begin
                {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                r_cnt          <= r_cnt + 1'b1;
                if (r_cnt == CNT_W'(SCORE_W - 1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;

endmodule

// File: rtl/score_display_ctrl.sv
// Score display driver: converts the score to BCD for the 7-segment digits and
// scans a dot matrix showing a fill-level bar of the last captured score.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int BAR_SHIFT  = 7
) (
    input  logic                    clk2,
    input  logic                    reset,
    input  logic [SCORE_W-1:0]      score,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] seven,
    output logic [ROWS-1:0]         dot_row,
    output logic [COLS-1:0]         dot_col,
    output logic                    busy,
    output logic                    overflow
);

    localparam int BCD_W   = 4*NUM_DIGITS + 4;
    localparam int LIT_MAX = ROWS * COLS;
    localparam int LIT_W   = $clog2(LIT_MAX + 1);
    localparam int PART_W  = $clog2(COLS);
    localparam int FULL_W  = LIT_W - PART_W;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t                  r_state;
    logic [SCORE_W-1:0]      r_last_score;
    logic                    r_last_valid;
    logic [7*NUM_DIGITS-1:0] r_seven;
    logic                    r_overflow;
    logic                    r_busy;
    logic [ROW_W-1:0]        r_row_cnt;
    logic [ROWS-1:0]         r_dot_row;
    logic [COLS-1:0]         r_dot_col;

    logic                    w_start;
    logic                    w_done;
    logic [BCD_W-1:0]        w_bcd;
    logic                    w_ovf;
    logic [7*NUM_DIGITS-1:0] w_seven_next;
    logic [NUM_DIGITS:1]     w_nz_from;

    assign w_start = (r_state == IDLE) && (!r_last_valid || (score != r_last_score));

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .BCD_W   (BCD_W)
    ) u_bin2bcd (
        .clk2  (clk2),
        .reset (reset),
        .start (w_start),
        .score (score),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    // Anything left in the guard nibble means the score needs more digits.
    assign w_ovf = |w_bcd[BCD_W-1:4*NUM_DIGITS];
    assign w_nz_from[NUM_DIGITS] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] w_digit;
            logic       w_blank;
            assign w_digit = w_bcd[4*gi +: 4];
            if (gi == 0) begin : g_ones
                assign w_blank = 1'b0;
            end else begin : g_upper
                assign w_nz_from[gi] = (w_digit != 4'd0) | w_nz_from[gi+1];
                assign w_blank       = blank_lz & ~w_nz_from[gi];
            end
            assign w_seven_next[7*gi +: 7] = w_ovf   ? seg7_encode(4'd9) :
                                             w_blank ? SEG_BLANK         :
                                                       seg7_encode(w_digit);
        end
    endgenerate

    always_ff @(posedge clk2) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_score <= '0;
            r_last_valid <= 1'b0;
            r_seven      <= '1;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_last_score <= score;
                        r_last_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_done) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_seven    <= w_seven_next;
                    r_overflow <= w_ovf;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bar geometry from the last captured score, clamped to the matrix size.
    logic [SCORE_W-1:0] w_lit_raw;
    logic [LIT_W-1:0]   w_lit;
    logic [FULL_W-1:0]  w_full;
    logic [PART_W-1:0]  w_part;
    logic [COLS-1:0]    w_part_mask;
    logic [ROWS-1:0]    w_row_sel;
    logic [FULL_W-1:0]  w_row_ext;

    assign w_lit_raw   = r_last_score >> BAR_SHIFT;
    assign w_lit       = (w_lit_raw > SCORE_W'(LIT_MAX)) ? LIT_W'(LIT_MAX) : w_lit_raw[LIT_W-1:0];
    assign w_full      = w_lit[LIT_W-1:PART_W];
    assign w_part      = w_lit[PART_W-1:0];
    assign w_part_mask = ~({COLS{1'b1}} >> w_part);
    assign w_row_ext   = FULL_W'(r_row_cnt);

    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row_sel
            assign w_row_sel[gi] = (r_row_cnt != ROW_W'(ROWS - 1 - gi));
        end
    endgenerate

    always_ff @(posedge clk2) begin
        if (reset) begin
            r_row_cnt <= '0;
            r_dot_row <= '1;
            r_dot_col <= '0;
        end else begin
            r_row_cnt <= (r_row_cnt == ROW_W'(ROWS - 1)) ? '0 : r_row_cnt + 1'b1;
            r_dot_row <= w_row_sel;
            if (w_row_ext < w_full) begin
                r_dot_col <= '1;
            end else if (w_row_ext == w_full) begin
                r_dot_col <= w_part_mask;
            end else begin
                r_dot_col <= '0;
            end
        end
    end

    assign seven    = r_seven;
    assign overflow = r_overflow;
    assign busy     = r_busy;
    assign dot_row  = r_dot_row;
    assign dot_col  = r_dot_col;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: the driver pushes expected displays
// computed arithmetically, a monitor pops them whenever a conversion completes.
module tb_score_display_ctrl;

    localparam int SCORE_W    = 14;
    localparam int NUM_DIGITS = 4;
    localparam int ROWS       = 8;
    localparam int COLS       = 8;
    localparam int BAR_SHIFT  = 7;

    logic                    clk2 = 1'b0;
    logic                    reset = 1'b1;
    logic [SCORE_W-1:0]      score = '0;
    logic                    blank_lz = 1'b0;
    logic [7*NUM_DIGITS-1:0] seven;
    logic [ROWS-1:0]         dot_row;
    logic [COLS-1:0]         dot_col;
    logic                    busy;
    logic                    overflow;

    score_display_ctrl #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .BAR_SHIFT  (BAR_SHIFT)
    ) dut (
        .clk2     (clk2),
        .reset    (reset),
        .score    (score),
        .blank_lz (blank_lz),
        .seven    (seven),
        .dot_row  (dot_row),
        .dot_col  (dot_col),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        logic [7*NUM_DIGITS-1:0] seven;
        logic                    ovf;
        int                      sc;
        bit                      blz;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_edges = 0;
    bit   mdl_valid = 1'b0;
    int   mdl_last  = 0;

    always @(posedge clk2) n_edges <= reset ? 0 : n_edges + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    // Decimal digits by division; leading zeros blanked above the top nonzero digit.
    function automatic exp_t model(input int sc, input bit blz);
        exp_t e;
        int   d[NUM_DIGITS];
        int   p = 1;
        int   limit = 1;
        int   hi = 0;
        e.sc = sc;
        e.blz = blz;
        for (int i = 0; i < NUM_DIGITS; i++) limit *= 10;
        e.ovf = (sc > limit - 1);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d[i] = (sc / p) % 10;
            if (d[i] != 0) hi = i;
            p *= 10;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (e.ovf)                e.seven[7*i +: 7] = glyph(9);
            else if (blz && (i > hi)) e.seven[7*i +: 7] = 7'h7F;
            else                      e.seven[7*i +: 7] = glyph(d[i]);
        end
        return e;
    endfunction

    initial begin : monitor
        bit   prev_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk2);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        $display("[TB] score=%0d blank_lz=%0b seven=%h overflow=%0b", e.sc, e.blz, seven, overflow);
                        check("seven", 64'(seven), 64'(e.seven));
                        check("overflow", 64'(overflow), 64'(e.ovf));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic wait_busy(input logic lvl, input string nm);
        int k = 0;
        while (busy !== lvl && k < 60) begin
            @(negedge clk2);
            k++;
        end
        check(nm, 64'(busy), 64'(lvl));
    endtask

    // Called at a negedge with the DUT idle.
    task automatic apply(input int sc, input bit blz);
        score    = SCORE_W'(sc);
        blank_lz = blz;
        if (!mdl_valid || sc != mdl_last) begin
            @(negedge clk2);
            check("busy_rise", 64'(busy), 64'd1);
            sb_q.push_back(model(sc, blz));
            mdl_valid = 1'b1;
            mdl_last  = sc;
            wait_busy(1'b0, "busy_fall");
            @(negedge clk2);
        end else begin
            repeat (3) @(negedge clk2);
            check("no_recapture", 64'(busy), 64'd0);
        end
    endtask

    task automatic apply_midchange(input int sc1, input int sc2, input bit blz);
        score    = SCORE_W'(sc1);
        blank_lz = blz;
        @(negedge clk2);
        check("busy_rise", 64'(busy), 64'd1);
        sb_q.push_back(model(sc1, blz));
        repeat (3) @(negedge clk2);
        score = SCORE_W'(sc2);
        sb_q.push_back(model(sc2, blz));
        mdl_valid = 1'b1;
        mdl_last  = sc2;
        wait_busy(1'b0, "busy_fall_first");
        @(negedge clk2);
        check("busy_reconvert", 64'(busy), 64'd1);
        wait_busy(1'b0, "busy_fall_second");
        @(negedge clk2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb_q.delete();
        mdl_valid = 1'b0;
        repeat (2) @(negedge clk2);
        check("rst_seven", 64'(seven), 64'(28'hFFFFFFF));
        check("rst_dot_row", 64'(dot_row), 64'hFF);
        check("rst_dot_col", 64'(dot_col), 64'h00);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
    endtask

    task automatic check_bar();
        int              lit, full, part, r;
        logic [ROWS-1:0] er;
        logic [COLS-1:0] ec;
        lit = mdl_last >> BAR_SHIFT;
        if (lit > ROWS*COLS) lit = ROWS*COLS;
        full = lit / COLS;
        part = lit % COLS;
        repeat (2*ROWS) begin
            @(negedge clk2);
            r  = (n_edges - 1) % ROWS;
            er = '1;
            er[ROWS-1-r] = 1'b0;
            if (r < full)       ec = '1;
            else if (r == full) ec = COLS'(((1 << part) - 1) << (COLS - part));
            else                ec = '0;
            check("dot_row", 64'(dot_row), 64'(er));
            check("dot_col", 64'(dot_col), 64'(ec));
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int  sc1, sc2;
        bit  blz;
        @(negedge clk2);
        do_reset();
        apply(0, 1'b0);
        check_bar();
        apply(1234, 1'b0);
        apply(12000, 1'b0);
        check_bar();
        apply(7, 1'b1);
        apply(0, 1'b1);
        apply(1000, 1'b0);
        check_bar();
        apply(1000, 1'b0);
        apply_midchange(1234, 5678, 1'b0);

        // Reset in the middle of a conversion aborts it.
        score = SCORE_W'(4321);
        @(negedge clk2);
        check("abort_busy_rise", 64'(busy), 64'd1);
        repeat (4) @(negedge clk2);
        reset = 1'b1;
        sb_q.delete();
        mdl_valid = 1'b0;
        @(negedge clk2);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_seven", 64'(seven), 64'(28'hFFFFFFF));
        @(negedge clk2);
        reset = 1'b0;
        apply(9999, 1'b1);
        apply(10000, 1'b0);
        apply(16383, 1'b0);
        check_bar();
        apply(90, 1'b1);

        for (int t = 0; t < 40; t++) begin
            sc1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 150)) : int'($urandom_range(0, 16383));
            blz = 1'($urandom_range(0, 1));
            if (t % 5 == 4) begin
                if (sc1 == mdl_last) sc1 = (sc1 + 1) % 16384;
                sc2 = int'($urandom_range(0, 16383));
                if (sc2 == sc1) sc2 = (sc2 + 1) % 16384;
                apply_midchange(sc1, sc2, blz);
            end else begin
                apply(sc1, blz);
            end
            if (t % 8 == 0) check_bar();
        end

        repeat (3) @(negedge clk2);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
